ham_select_seq: RTL and testbench

//  Multi-cycle "select" unit, the inverse of the Hamming-weight (rank/popcount) datapath.

---
 rtl/ham_select_seq.sv | 89 ++++++++
 tb/tb_ham_select_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ham_select_seq.sv
// Sequential select unit: finds the bit position of the n-th set bit of A
// (0-based, LSB first), scanning one bit per cycle under a start/done handshake.
module ham_select_seq #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [IDX_W-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] pos
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_r;
    logic [IDX_W-1:0]   n_r;
    logic [IDX_W-1:0]   idx;
    // one extra bit so a count of WIDTH set bits cannot wrap back onto n_r
    logic [IDX_W:0]     seen;
    logic               hit;
    logic               last;

    assign hit  = a_r[idx] && (seen == {1'b0, n_r});
    assign last = (idx == IDX_W'(WIDTH - 1));
    assign busy = (state == S_SCAN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN:  if (hit || last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            n_r   <= '0;
            idx   <= '0;
            seen  <= '0;
            found <= 1'b0;
            pos   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r  <= A;
                        n_r  <= n;
                        idx  <= '0;
                        seen <= '0;
                    end
                end
                S_SCAN: begin
                    // a match on the final bit takes priority over exhaustion
                    if (hit) begin
                        found <= 1'b1;
                        pos   <= idx;
                    end else if (last) begin
                        found <= 1'b0;
                        pos   <= '0;
                    end else begin
                        if (a_r[idx]) seen <= seen + 1'b1;
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ham_select_seq.sv
// Directed and small random bench for ham_select_seq: result, latency,
// one-cycle done pulse, start-ignored-while-busy and mid-scan reset.
module tb_ham_select_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [4:0]  n;
    logic        busy, done, found;
    logic [4:0]  pos;

    int checks   = 0;
    int failures = 0;

    ham_select_seq #(.WIDTH(32), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .n(n),
        .busy(busy), .done(done), .found(found), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: LSB-first scan counting set bits.
    function automatic void ref_sel(input logic [31:0] a, input logic [4:0] nn,
                                    output logic f, output logic [4:0] p);
        int cnt;
        cnt = 0;
        f = 1'b0;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                if (cnt == int'(nn) && !f) begin
                    f = 1'b1;
                    p = 5'(i);
                end
                cnt++;
            end
        end
    endfunction

    // Issue one op; latency counted so that done in cycle t+L gives lat=L.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] nn,
                          input logic ef, input logic [4:0] ep, input int elat,
                          input bit pulse_mid);
        int k;
        @(negedge clk);
        A = a; n = nn; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        n = 5'($urandom);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (pulse_mid && k == 3) start = 1'b1;
            if (pulse_mid && k == 4) start = 1'b0;
        end
        if (k >= 40) begin
            chk({tag, "_timeout"}, 32'(k), 32'(elat - 1));
        end else begin
            chk({tag, "_lat"}, 32'(k + 1), 32'(elat));
            chk({tag, "_found"}, 32'(found), 32'(ef));
            chk({tag, "_pos"}, 32'(pos), 32'(ep));
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, {26'd0, found, pos}, {26'd0, ef, ep});
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [4:0]  rn, rp;
        logic        rf;
        bit          saw_done;

        rst = 1'b1; start = 1'b0; A = '0; n = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {28'd0, busy, done, found, 1'b0} | 32'(pos), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1", 32'h0000_0001, 5'd0,  1'b1, 5'd0,  2,  1'b0);
        run_op("t2", 32'h8000_0000, 5'd0,  1'b1, 5'd31, 33, 1'b0);
        run_op("t3", 32'hF0F0_F0F0, 5'd5,  1'b1, 5'd13, 15, 1'b1);
        run_op("t4", 32'h0000_000F, 5'd4,  1'b0, 5'd0,  33, 1'b0);
        run_op("t5a", 32'hFFFF_FFFF, 5'd31, 1'b1, 5'd31, 33, 1'b0);
        run_op("t5b", 32'h0000_0000, 5'd0,  1'b0, 5'd0,  33, 1'b0);
        run_op("pre6", 32'h0000_0080, 5'd0, 1'b1, 5'd7,  9,  1'b0);

        // Mid-scan reset: rst sampled at edge t+10.
        @(negedge clk);
        A = 32'h8000_0000; n = 5'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_out", {28'd0, busy, done, found, 1'b0} | 32'(pos), 32'd0);
        rst = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("t6_no_done", 32'(saw_done), 32'd0);
        run_op("t6_after", 32'h0000_0100, 5'd0, 1'b1, 5'd8, 10, 1'b0);

        // Random ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            if (i % 4 == 1) ra = ra & $urandom;
            if (i % 4 == 2) ra = ra | $urandom;
            rn = 5'($urandom_range(0, 31));
            ref_sel(ra, rn, rf, rp);
            run_op("rnd", ra, rn, rf, rp, rf ? int'(rp) + 2 : 33, 1'b0);
            chk("rnd_rank", 32'(found), 32'(int'(rn) < $countones(ra)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
